// File: rtl/dcache_assoc_pkg.sv
// Shared bus, size and state encodings plus the line record for the set-associative data cache.
package dcache_assoc_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WB_REQ    = 2'd1,
        FILL_REQ  = 2'd2,
        FILL_WAIT = 2'd3
    } DCACHE_STATE;

    localparam int DCACHE_LINE_BYTES = 8;
    localparam int MAX_TAG_W         = 32;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [MAX_TAG_W-1:0] tag;
        logic [63:0]          data;
    } DCACHE_LINE;

endpackage

// File: rtl/dcache_lru.sv
// Per-set age-based replacement: picks a victim for the looked-up set and ages the other ways on each access.
module dcache_lru #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    localparam int IDX_W = $clog2(NUM_SETS),
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IDX_W-1:0]    lookup_set,
    input  logic [NUM_WAYS-1:0] lookup_valid,
    input  logic                touch,
    input  logic [IDX_W-1:0]    touch_set,
    input  logic [WAY_W-1:0]    touch_way,
    output logic [WAY_W-1:0]    victim
);

    generate
        if (NUM_WAYS == 1) begin : g_direct
            logic unused;
            assign unused = ^{clock, reset, lookup_set, lookup_valid, touch, touch_set, touch_way};
            assign victim = '0;
        end else begin : g_lru
            logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];
            logic [WAY_W-1:0] best_age;
            logic             found;

            // Invalid ways are filled first; otherwise the oldest way wins, ties to the lowest index.
            always_comb begin
                victim   = '0;
                best_age = '0;
                found    = 1'b0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (!found && !lookup_valid[w]) begin
                        victim = WAY_W'(w);
                        found  = 1'b1;
                    end
                end
                if (!found) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (age[lookup_set][w] > best_age) begin
                            best_age = age[lookup_set][w];
                            victim   = WAY_W'(w);
                        end
                    end
                end
            end

            // Ways no older than the touched one age by one; equal ages count so that all-zero sets still separate.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < NUM_SETS; s++)
                        for (int w = 0; w < NUM_WAYS; w++)
                            age[s][w] <= '0;
                end else if (touch) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        if (WAY_W'(w) == touch_way)
                            age[touch_set][w] <= '0;
                        else if (age[touch_set][w] <= age[touch_set][touch_way] && age[touch_set][w] != '1)
                            age[touch_set][w] <= age[touch_set][w] + 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache with one outstanding miss on a tagged memory bus.
module dcache_assoc #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    parameter int XLEN     = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2Dcache_command,
    input  logic [XLEN-1:0] proc2Dcache_addr,
    input  logic [1:0]      proc2Dcache_size,
    input  logic [63:0]     proc2Dcache_data,
    output logic [63:0]     Dcache_data_out,
    output logic            Dcache_valid_out,
    output logic [1:0]      proc2Dmem_command,
    output logic [XLEN-1:0] proc2Dmem_addr,
    output logic [63:0]     proc2Dmem_data,
    input  logic [3:0]      Dmem2proc_response,
    input  logic [63:0]     Dmem2proc_data,
    input  logic [3:0]      Dmem2proc_tag
);
    import dcache_assoc_pkg::*;

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LINE_W = XLEN - 3;
    localparam int TAG_W  = LINE_W - IDX_W;

    logic [NUM_WAYS-1:0] valid_arr [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_arr [NUM_SETS];
    logic [TAG_W-1:0]    tag_arr   [NUM_SETS][NUM_WAYS];
    logic [63:0]         data_arr  [NUM_SETS][NUM_WAYS];

    DCACHE_STATE       state;
    logic [3:0]        mem_tag;
    logic [LINE_W-1:0] miss_line;
    logic [WAY_W-1:0]  miss_way;

    logic [LINE_W-1:0] req_line;
    logic [IDX_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  miss_set;
    logic              active;
    logic              hit;
    logic              store_hit;
    logic              fill_done;
    logic              victim_dirty;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;

    function automatic logic [63:0] merge_store(input logic [63:0] line, input logic [63:0] wdata,
                                                input logic [2:0] offset, input logic [1:0] size);
        logic [63:0] merged;
        int          nbytes;
        merged = line;
        nbytes = 1 << size;
        for (int b = 0; b < DCACHE_LINE_BYTES; b++) begin
            if (b >= int'(offset) && b < int'(offset) + nbytes)
                merged[8*b +: 8] = wdata[8*(b - int'(offset)) +: 8];
        end
        return merged;
    endfunction

    assign req_line  = proc2Dcache_addr[XLEN-1:3];
    assign req_set   = req_line[IDX_W-1:0];
    assign req_tag   = req_line[LINE_W-1:IDX_W];
    assign miss_set  = miss_line[IDX_W-1:0];
    assign active    = (state == IDLE) && (proc2Dcache_command != BUS_NONE);
    assign store_hit = hit && (proc2Dcache_command == BUS_STORE);
    // A tag only completes the fill once we are actually waiting for it.
    assign fill_done = (state == FILL_WAIT) && (Dmem2proc_tag != 4'd0) && (Dmem2proc_tag == mem_tag);
    assign victim_dirty = valid_arr[req_set][victim] && dirty_arr[req_set][victim];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (active && valid_arr[req_set][w] && tag_arr[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign Dcache_valid_out = hit;
    assign Dcache_data_out  = hit ? data_arr[req_set][hit_way] : 64'd0;

    dcache_lru #(
        .NUM_SETS(NUM_SETS),
        .NUM_WAYS(NUM_WAYS)
    ) u_lru (
        .clock       (clock),
        .reset       (reset),
        .lookup_set  (req_set),
        .lookup_valid(valid_arr[req_set]),
        .touch       (hit || fill_done),
        .touch_set   (fill_done ? miss_set : req_set),
        .touch_way   (fill_done ? miss_way : hit_way),
        .victim      (victim)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            mem_tag           <= 4'd0;
            miss_line         <= '0;
            miss_way          <= '0;
            proc2Dmem_command <= BUS_NONE;
            proc2Dmem_addr    <= '0;
            proc2Dmem_data    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (store_hit) begin
                        dirty_arr[req_set][hit_way] <= 1'b1;
                    end else if (active && !hit) begin
                        miss_line <= req_line;
                        miss_way  <= victim;
                        if (victim_dirty) begin
                            state             <= WB_REQ;
                            proc2Dmem_command <= BUS_STORE;
                            proc2Dmem_addr    <= {tag_arr[req_set][victim], req_set, 3'b000};
                            proc2Dmem_data    <= data_arr[req_set][victim];
                        end else begin
                            state             <= FILL_REQ;
                            proc2Dmem_command <= BUS_LOAD;
                            proc2Dmem_addr    <= {req_line, 3'b000};
                        end
                    end
                end
                WB_REQ: begin
                    if (Dmem2proc_response != 4'd0) begin
                        state             <= FILL_REQ;
                        proc2Dmem_command <= BUS_LOAD;
                        proc2Dmem_addr    <= {miss_line, 3'b000};
                        proc2Dmem_data    <= '0;
                    end
                end
                FILL_REQ: begin
                    if (Dmem2proc_response != 4'd0) begin
                        mem_tag           <= Dmem2proc_response;
                        state             <= FILL_WAIT;
                        proc2Dmem_command <= BUS_NONE;
                        proc2Dmem_addr    <= '0;
                    end
                end
                FILL_WAIT: begin
                    if (fill_done) begin
                        valid_arr[miss_set][miss_way] <= 1'b1;
                        dirty_arr[miss_set][miss_way] <= 1'b0;
                        mem_tag                       <= 4'd0;
                        state                         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line contents carry no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clock) begin
        if (store_hit)
            data_arr[req_set][hit_way] <= merge_store(data_arr[req_set][hit_way], proc2Dcache_data,
                                                      proc2Dcache_addr[2:0], proc2Dcache_size);
        if (fill_done) begin
            tag_arr[miss_set][miss_way]  <= miss_line[LINE_W-1:IDX_W];
            data_arr[miss_set][miss_way] <= Dmem2proc_data;
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: directed scenarios plus random traffic against a behavioural cache/memory model.
module tb_dcache_assoc;
    import dcache_assoc_pkg::*;

    logic        clock;
    logic        reset;
    logic [1:0]  proc2Dcache_command;
    logic [31:0] proc2Dcache_addr;
    logic [1:0]  proc2Dcache_size;
    logic [63:0] proc2Dcache_data;
    logic [63:0] Dcache_data_out;
    logic        Dcache_valid_out;
    logic [1:0]  proc2Dmem_command;
    logic [31:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic [3:0]  Dmem2proc_response;
    logic [63:0] Dmem2proc_data;
    logic [3:0]  Dmem2proc_tag;

    dcache_assoc dut (
        .clock              (clock),
        .reset              (reset),
        .proc2Dcache_command(proc2Dcache_command),
        .proc2Dcache_addr   (proc2Dcache_addr),
        .proc2Dcache_size   (proc2Dcache_size),
        .proc2Dcache_data   (proc2Dcache_data),
        .Dcache_data_out    (Dcache_data_out),
        .Dcache_valid_out   (Dcache_valid_out),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .Dmem2proc_response (Dmem2proc_response),
        .Dmem2proc_data     (Dmem2proc_data),
        .Dmem2proc_tag      (Dmem2proc_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: 16 sets x 2 ways, LRU by last-use timestamp, backing memory keyed by line number.
    bit          m_valid [16][2];
    bit          m_dirty [16][2];
    logic [24:0] m_tag   [16][2];
    logic [63:0] m_data  [16][2];
    int          m_used  [16][2];
    int          tick = 0;
    logic [63:0] mem [logic [28:0]];

    int          k_rej  = -1;
    logic [3:0]  k_tag  = 4'd0;
    logic [3:0]  k_spur = 4'd0;

    bit          last_hit;
    int          load_cycles;
    logic [31:0] last_load_addr;
    logic [31:0] last_wb_addr;
    logic [63:0] last_wb_data;
    logic [63:0] last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [28:0] line);
        if (mem.exists(line)) return mem[line];
        return {3'b000, line, 3'b000, ~line};
    endfunction

    function automatic int pick_victim(input logic [3:0] s);
        int v;
        for (int w = 0; w < 2; w++) if (!m_valid[s][w]) return w;
        v = 0;
        for (int w = 1; w < 2; w++) if (m_used[s][w] < m_used[s][v]) v = w;
        return v;
    endfunction

    task automatic touch(input logic [3:0] s, input int w);
        tick++;
        m_used[s][w] = tick;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_used[s][w]  = 0;
            end
    endtask

    function automatic logic [63:0] model_merge(input logic [63:0] line, input logic [63:0] wd,
                                                input int off, input int size);
        logic [7:0]  b [8];
        logic [63:0] r;
        for (int i = 0; i < 8; i++) b[i] = line[8*i +: 8];
        for (int i = 0; i < (1 << size); i++) if (off + i < 8) b[off + i] = wd[8*i +: 8];
        for (int i = 0; i < 8; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    // One cycle: sample outputs at the falling edge, then step past the next rising edge.
    task automatic cyc(input bit ev, input bit chkdata, input logic [63:0] ed, input logic [1:0] ecmd,
                       input logic [31:0] eaddr, input bit chkw, input logic [63:0] ew);
        @(negedge clock);
        chk("valid_out", {63'd0, Dcache_valid_out}, {63'd0, ev});
        if (chkdata) chk("data_out", Dcache_data_out, ed);
        chk("mem_command", {62'd0, proc2Dmem_command}, {62'd0, ecmd});
        if (ecmd != BUS_NONE) chk("mem_addr", {32'd0, proc2Dmem_addr}, {32'd0, eaddr});
        if (chkw) chk("mem_wdata", proc2Dmem_data, ew);
        if (proc2Dmem_command == BUS_LOAD) begin
            load_cycles++;
            last_load_addr = proc2Dmem_addr;
        end
        if (proc2Dmem_command == BUS_STORE) begin
            last_wb_addr = proc2Dmem_addr;
            last_wb_data = proc2Dmem_data;
        end
        if (Dcache_valid_out) last_data = Dcache_data_out;
        @(posedge clock);
        #1;
    endtask

    task automatic access(input logic [1:0] cmd, input logic [31:0] addr, input logic [1:0] size,
                          input logic [63:0] wd);
        logic [3:0]  s;
        logic [24:0] t;
        logic [3:0]  tg;
        logic [3:0]  x;
        logic [31:0] wa;
        int          hw;
        int          v;
        int          nr;
        int          dl;
        s  = addr[6:3];
        t  = addr[31:7];
        hw = -1;
        for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        proc2Dcache_command = cmd;
        proc2Dcache_addr    = addr;
        proc2Dcache_size    = size;
        proc2Dcache_data    = wd;
        last_hit    = (hw >= 0);
        load_cycles = 0;
        if (hw < 0) begin
            cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
            v = pick_victim(s);
            if (m_valid[s][v] && m_dirty[s][v]) begin
                wa = {m_tag[s][v], s, 3'b000};
                nr = $urandom_range(0, 2);
                for (int i = 0; i <= nr; i++) begin
                    Dmem2proc_response = (i == nr) ? 4'($urandom_range(1, 15)) : 4'd0;
                    cyc(1'b0, 1'b0, 64'd0, BUS_STORE, wa, 1'b1, m_data[s][v]);
                end
                Dmem2proc_response = 4'd0;
                mem[wa[31:3]] = m_data[s][v];
            end
            nr = (k_rej >= 0) ? k_rej : $urandom_range(0, 2);
            tg = (k_tag != 4'd0) ? k_tag : 4'($urandom_range(1, 15));
            for (int i = 0; i <= nr; i++) begin
                Dmem2proc_response = (i == nr) ? tg : 4'd0;
                cyc(1'b0, 1'b0, 64'd0, BUS_LOAD, {addr[31:3], 3'b000}, 1'b0, 64'd0);
            end
            Dmem2proc_response = 4'd0;
            if (k_spur != 4'd0) begin
                Dmem2proc_tag  = k_spur;
                Dmem2proc_data = 64'hBAD0_BAD0_BAD0_BAD0;
                cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
            end
            dl = $urandom_range(0, 2);
            for (int i = 0; i < dl; i++) begin
                x = 4'($urandom_range(0, 15));
                if (x == tg) x = 4'd0;
                Dmem2proc_tag  = x;
                Dmem2proc_data = {$urandom, $urandom};
                cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
            end
            Dmem2proc_tag  = tg;
            Dmem2proc_data = mem_rd(addr[31:3]);
            cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
            Dmem2proc_tag  = 4'd0;
            Dmem2proc_data = {$urandom, $urandom};
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_tag[s][v]   = t;
            m_data[s][v]  = mem_rd(addr[31:3]);
            touch(s, v);
            hw = v;
        end
        cyc(1'b1, cmd == BUS_LOAD, m_data[s][hw], BUS_NONE, 32'd0, 1'b0, 64'd0);
        if (cmd == BUS_STORE) begin
            m_data[s][hw]  = model_merge(m_data[s][hw], wd, int'(addr[2:0]), int'(size));
            m_dirty[s][hw] = 1'b1;
        end
        touch(s, hw);
        proc2Dcache_command = BUS_NONE;
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rsz;
        logic [1:0]  rcmd;
        int          v6;
        reset               = 1'b1;
        proc2Dcache_command = BUS_NONE;
        proc2Dcache_addr    = 32'd0;
        proc2Dcache_size    = 2'd0;
        proc2Dcache_data    = 64'd0;
        Dmem2proc_response  = 4'd0;
        Dmem2proc_data      = 64'd0;
        Dmem2proc_tag       = 4'd0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset_valid_out", {63'd0, Dcache_valid_out}, 64'd0);
        chk("reset_data_out", Dcache_data_out, 64'd0);
        chk("reset_mem_command", {62'd0, proc2Dmem_command}, {62'd0, BUS_NONE});
        chk("reset_mem_addr", {32'd0, proc2Dmem_addr}, 64'd0);
        chk("reset_mem_data", proc2Dmem_data, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b1, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);

        // Load miss filled by tag 3.
        mem[29'h20] = 64'h88;
        k_rej = 0; k_tag = 4'd3;
        access(BUS_LOAD, 32'h100, DOUBLE, 64'd0);
        k_rej = -1; k_tag = 4'd0;
        chk("t1_load_cycles", 64'(load_cycles), 64'd1);
        chk("t1_load_addr", {32'd0, last_load_addr}, 64'h100);
        chk("t1_data", last_data, 64'h88);

        // Store hit then reload.
        access(BUS_STORE, 32'h104, WORD, 64'hDEADBEEF);
        chk("t2_store_hit", {63'd0, last_hit}, 64'd1);
        access(BUS_LOAD, 32'h100, DOUBLE, 64'd0);
        chk("t2_reload_data", last_data, 64'hDEADBEEF_00000088);
        chk("t2_reload_no_bus", 64'(load_cycles), 64'd0);

        // Conflict in set 0 evicts dirty 0x100.
        access(BUS_LOAD, 32'h200, DOUBLE, 64'd0);
        access(BUS_LOAD, 32'h300, DOUBLE, 64'd0);
        chk("t3_wb_addr", {32'd0, last_wb_addr}, 64'h100);
        chk("t3_wb_data", last_wb_data, 64'hDEADBEEF_00000088);
        chk("t3_fill_addr", {32'd0, last_load_addr}, 64'h300);
        access(BUS_LOAD, 32'h200, DOUBLE, 64'd0);
        chk("t3_mru_hit", {63'd0, last_hit}, 64'd1);

        // Three rejections, accept with tag 5, stray tag 4 first.
        mem[29'h83] = 64'h4444;
        k_rej = 3; k_tag = 4'd5; k_spur = 4'd4;
        access(BUS_LOAD, 32'h418, DOUBLE, 64'd0);
        k_rej = -1; k_tag = 4'd0; k_spur = 4'd0;
        chk("t4_load_cycles", 64'(load_cycles), 64'd4);
        chk("t4_data", last_data, 64'h4444);

        // Reset while waiting for tag 7; the late tag must not install.
        proc2Dcache_command = BUS_LOAD;
        proc2Dcache_addr    = 32'h588;
        proc2Dcache_size    = DOUBLE;
        load_cycles         = 0;
        cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
        Dmem2proc_response = 4'd7;
        cyc(1'b0, 1'b0, 64'd0, BUS_LOAD, 32'h588, 1'b0, 64'd0);
        Dmem2proc_response  = 4'd0;
        proc2Dcache_command = BUS_NONE;
        reset               = 1'b1;
        cyc(1'b0, 1'b1, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
        reset          = 1'b0;
        Dmem2proc_tag  = 4'd7;
        Dmem2proc_data = 64'h7777;
        cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
        Dmem2proc_tag = 4'd0;
        model_reset();
        access(BUS_LOAD, 32'h588, DOUBLE, 64'd0);
        chk("t5_refetch", {63'd0, load_cycles > 0}, 64'd1);

        // Command dropped during FILL_WAIT; the line still installs.
        mem[29'hC2] = 64'h66;
        proc2Dcache_command = BUS_LOAD;
        proc2Dcache_addr    = 32'h610;
        cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
        v6 = pick_victim(4'd2);
        Dmem2proc_response = 4'd9;
        cyc(1'b0, 1'b0, 64'd0, BUS_LOAD, 32'h610, 1'b0, 64'd0);
        Dmem2proc_response  = 4'd0;
        proc2Dcache_command = BUS_NONE;
        cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
        cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
        Dmem2proc_tag  = 4'd9;
        Dmem2proc_data = 64'h66;
        cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
        Dmem2proc_tag = 4'd0;
        m_valid[2][v6] = 1'b1;
        m_dirty[2][v6] = 1'b0;
        m_tag[2][v6]   = 25'hC;
        m_data[2][v6]  = 64'h66;
        touch(4'd2, v6);
        cyc(1'b0, 1'b0, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
        access(BUS_LOAD, 32'h610, DOUBLE, 64'd0);
        chk("t6_hit_model", {63'd0, last_hit}, 64'd1);
        chk("t6_data", last_data, 64'h66);

        // Random traffic over a few sets and tags to force conflicts and evictions.
        for (int n = 0; n < 300; n++) begin
            rsz  = 2'($urandom_range(0, 3));
            rcmd = ($urandom_range(0, 1) == 0) ? BUS_LOAD : BUS_STORE;
            ra   = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 3)) << 3);
            ra[2:0] = 3'($urandom_range(0, 7)) & ~(3'((1 << rsz) - 1));
            access(rcmd, ra, rsz, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0)
                cyc(1'b0, 1'b1, 64'd0, BUS_NONE, 32'd0, 1'b0, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
